// File: rtl/itch_add_broken_decoder.sv
// ITCH 5.0 Add Order ('A'), Add Order with MPID ('F') and Broken Trade ('B') decoder on the byte ingress bus.
// Optional side-byte validation for 'A'/'F' is enabled by defining ITCH_SIDE_CHECK_EN.
module itch_add_broken_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        valid_in,
   output logic        add_internal_valid,
   output logic        add_mpid_internal_valid,
   output logic        broken_internal_valid,
   output logic        add_packet_invalid,
   output logic        add_mpid_packet_invalid,
   output logic        broken_packet_invalid,
   output logic [3:0]  add_parsed_type,
   output logic [3:0]  add_mpid_parsed_type,
   output logic [3:0]  broken_parsed_type,
   output logic [63:0] add_order_ref,
   output logic [63:0] add_mpid_order_ref,
   output logic        add_side,
   output logic        add_mpid_side,
   output logic [31:0] add_shares,
   output logic [31:0] add_mpid_shares,
   output logic [31:0] add_price,
   output logic [31:0] add_mpid_price,
   output logic [63:0] add_stock_symbol,
   output logic [63:0] add_mpid_stock_symbol,
   output logic [31:0] add_mpid_attribution,
   output logic [47:0] broken_timestamp,
   output logic [63:0] broken_match_id
);
   typedef enum logic {S_IDLE = 1'b0, S_BODY = 1'b1} state_t;
   localparam logic [1:0] K_OTHER = 2'd0, K_ADD = 2'd1, K_MPID = 2'd2, K_BRK = 2'd3;

   // Total message length including the type byte; unknown types are one byte long.
   function automatic logic [5:0] msg_len(input logic [7:0] t);
      case (t)
         8'h53, 8'h57:               msg_len = 6'd12;
         8'h52:                      msg_len = 6'd39;
         8'h48:                      msg_len = 6'd25;
         8'h59, 8'h4E:               msg_len = 6'd20;
         8'h4C:                      msg_len = 6'd26;
         8'h56, 8'h4A, 8'h55:        msg_len = 6'd35;
         8'h4B:                      msg_len = 6'd28;
         8'h68:                      msg_len = 6'd21;
         8'h41, 8'h43:               msg_len = 6'd36;
         8'h46, 8'h51:               msg_len = 6'd40;
         8'h45:                      msg_len = 6'd31;
         8'h58:                      msg_len = 6'd23;
         8'h44, 8'h42:               msg_len = 6'd19;
         8'h50:                      msg_len = 6'd44;
         8'h49:                      msg_len = 6'd50;
         default:                    msg_len = 6'd1;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d, last_q, last_d, len_s;
   logic [1:0]  kind_q, kind_d;
   logic        side_err_q, side_err_d, side_bad_s;
   logic        add_fld_s, mpid_fld_s, brk_fld_s;
   logic        add_v_q, add_v_d, mpid_v_q, mpid_v_d, brk_v_q, brk_v_d;
   logic        add_i_q, add_i_d, mpid_i_q, mpid_i_d, brk_i_q, brk_i_d;
   logic [3:0]  add_pt_q, add_pt_d, mpid_pt_q, mpid_pt_d, brk_pt_q, brk_pt_d;
   logic [63:0] add_ref_q, add_ref_d, mpid_ref_q, mpid_ref_d;
   logic        add_side_q, add_side_d, mpid_side_q, mpid_side_d;
   logic [31:0] add_sh_q, add_sh_d, mpid_sh_q, mpid_sh_d;
   logic [31:0] add_pr_q, add_pr_d, mpid_pr_q, mpid_pr_d;
   logic [63:0] add_stk_q, add_stk_d, mpid_stk_q, mpid_stk_d;
   logic [31:0] mpid_at_q, mpid_at_d;
   logic [47:0] brk_ts_q, brk_ts_d;
   logic [63:0] brk_mid_q, brk_mid_d;

   // Framing, field capture and pulse generation for the next cycle.
   always_comb begin
      state_d = state_q;  cnt_d = cnt_q;  last_d = last_q;  kind_d = kind_q;  side_err_d = side_err_q;
      add_v_d = 1'b0;  mpid_v_d = 1'b0;  brk_v_d = 1'b0;
      add_i_d = 1'b0;  mpid_i_d = 1'b0;  brk_i_d = 1'b0;
      add_pt_d = add_pt_q;  mpid_pt_d = mpid_pt_q;  brk_pt_d = brk_pt_q;
      add_ref_d = add_ref_q;  mpid_ref_d = mpid_ref_q;  add_side_d = add_side_q;  mpid_side_d = mpid_side_q;
      add_sh_d = add_sh_q;  mpid_sh_d = mpid_sh_q;  add_pr_d = add_pr_q;  mpid_pr_d = mpid_pr_q;
      add_stk_d = add_stk_q;  mpid_stk_d = mpid_stk_q;  mpid_at_d = mpid_at_q;
      brk_ts_d = brk_ts_q;  brk_mid_d = brk_mid_q;
      len_s = msg_len(byte_in);
`ifdef ITCH_SIDE_CHECK_EN
      side_bad_s = (byte_in != 8'h42) && (byte_in != 8'h53);
`else
      side_bad_s = 1'b0;
`endif
      add_fld_s  = (kind_q == K_ADD);
      mpid_fld_s = (kind_q == K_MPID);
      brk_fld_s  = (kind_q == K_BRK);
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               case (byte_in)
                  8'h41:   kind_d = K_ADD;
                  8'h46:   kind_d = K_MPID;
                  8'h42:   kind_d = K_BRK;
                  default: kind_d = K_OTHER;
               endcase
               add_pt_d   = (byte_in == 8'h41) ? 4'h1 : 4'h0;
               mpid_pt_d  = (byte_in == 8'h46) ? 4'h2 : 4'h0;
               brk_pt_d   = (byte_in == 8'h42) ? 4'h3 : 4'h0;
               side_err_d = 1'b0;
               last_d     = len_s - 6'd1;
               if (len_s > 6'd1) begin
                  state_d = S_BODY;
                  cnt_d   = 6'd1;
               end else begin
                  cnt_d   = 6'd0;
               end
            end else begin
               cnt_d = 6'd0;
            end
         end
         S_BODY: begin
            if (valid_in) begin
               if (cnt_q >= 6'd5 && cnt_q <= 6'd10) begin
                  if (brk_fld_s) brk_ts_d = {brk_ts_q[39:0], byte_in};
                  else begin end
               end else if (cnt_q >= 6'd11 && cnt_q <= 6'd18) begin
                  if (add_fld_s)       add_ref_d  = {add_ref_q[55:0], byte_in};
                  else if (mpid_fld_s) mpid_ref_d = {mpid_ref_q[55:0], byte_in};
                  else if (brk_fld_s)  brk_mid_d  = {brk_mid_q[55:0], byte_in};
                  else begin end
               end else if (cnt_q == 6'd19) begin
                  if (add_fld_s)       begin add_side_d  = (byte_in == 8'h42); side_err_d = side_bad_s; end
                  else if (mpid_fld_s) begin mpid_side_d = (byte_in == 8'h42); side_err_d = side_bad_s; end
                  else begin end
               end else if (cnt_q >= 6'd20 && cnt_q <= 6'd23) begin
                  if (add_fld_s)       add_sh_d  = {add_sh_q[23:0], byte_in};
                  else if (mpid_fld_s) mpid_sh_d = {mpid_sh_q[23:0], byte_in};
                  else begin end
               end else if (cnt_q >= 6'd24 && cnt_q <= 6'd31) begin
                  if (add_fld_s)       add_stk_d  = {add_stk_q[55:0], byte_in};
                  else if (mpid_fld_s) mpid_stk_d = {mpid_stk_q[55:0], byte_in};
                  else begin end
               end else if (cnt_q >= 6'd32 && cnt_q <= 6'd35) begin
                  if (add_fld_s)       add_pr_d  = {add_pr_q[23:0], byte_in};
                  else if (mpid_fld_s) mpid_pr_d = {mpid_pr_q[23:0], byte_in};
                  else begin end
               end else if (cnt_q >= 6'd36 && cnt_q <= 6'd39) begin
                  if (mpid_fld_s) mpid_at_d = {mpid_at_q[23:0], byte_in};
                  else begin end
               end else begin
               end
               if (cnt_q == last_q) begin
                  state_d = S_IDLE;
                  cnt_d   = 6'd0;
                  case (kind_q)
                     K_ADD:   begin add_v_d  = ~side_err_q; add_i_d  = side_err_q; end
                     K_MPID:  begin mpid_v_d = ~side_err_q; mpid_i_d = side_err_q; end
                     K_BRK:   brk_v_d = 1'b1;
                     default: begin end
                  endcase
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else begin
               // Bus went idle mid-message: abandon it and flag target types as bad.
               state_d   = S_IDLE;
               cnt_d     = 6'd0;
               add_i_d   = add_fld_s;
               mpid_i_d  = mpid_fld_s;
               brk_i_d   = brk_fld_s;
               add_pt_d  = 4'h0;
               mpid_pt_d = 4'h0;
               brk_pt_d  = 4'h0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;  cnt_q <= 6'd0;  last_q <= 6'd0;  kind_q <= K_OTHER;  side_err_q <= 1'b0;
         add_v_q <= 1'b0;  mpid_v_q <= 1'b0;  brk_v_q <= 1'b0;
         add_i_q <= 1'b0;  mpid_i_q <= 1'b0;  brk_i_q <= 1'b0;
         add_pt_q <= 4'h0;  mpid_pt_q <= 4'h0;  brk_pt_q <= 4'h0;
         add_ref_q <= 64'h0;  mpid_ref_q <= 64'h0;  add_side_q <= 1'b0;  mpid_side_q <= 1'b0;
         add_sh_q <= 32'h0;  mpid_sh_q <= 32'h0;  add_pr_q <= 32'h0;  mpid_pr_q <= 32'h0;
         add_stk_q <= 64'h0;  mpid_stk_q <= 64'h0;  mpid_at_q <= 32'h0;
         brk_ts_q <= 48'h0;  brk_mid_q <= 64'h0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;  last_q <= last_d;  kind_q <= kind_d;  side_err_q <= side_err_d;
         add_v_q <= add_v_d;  mpid_v_q <= mpid_v_d;  brk_v_q <= brk_v_d;
         add_i_q <= add_i_d;  mpid_i_q <= mpid_i_d;  brk_i_q <= brk_i_d;
         add_pt_q <= add_pt_d;  mpid_pt_q <= mpid_pt_d;  brk_pt_q <= brk_pt_d;
         add_ref_q <= add_ref_d;  mpid_ref_q <= mpid_ref_d;  add_side_q <= add_side_d;  mpid_side_q <= mpid_side_d;
         add_sh_q <= add_sh_d;  mpid_sh_q <= mpid_sh_d;  add_pr_q <= add_pr_d;  mpid_pr_q <= mpid_pr_d;
         add_stk_q <= add_stk_d;  mpid_stk_q <= mpid_stk_d;  mpid_at_q <= mpid_at_d;
         brk_ts_q <= brk_ts_d;  brk_mid_q <= brk_mid_d;
      end
   end

   assign add_internal_valid      = add_v_q;
   assign add_mpid_internal_valid = mpid_v_q;
   assign broken_internal_valid   = brk_v_q;
   assign add_packet_invalid      = add_i_q;
   assign add_mpid_packet_invalid = mpid_i_q;
   assign broken_packet_invalid   = brk_i_q;
   assign add_parsed_type         = add_pt_q;
   assign add_mpid_parsed_type    = mpid_pt_q;
   assign broken_parsed_type      = brk_pt_q;
   assign add_order_ref           = add_ref_q;
   assign add_mpid_order_ref      = mpid_ref_q;
   assign add_side                = add_side_q;
   assign add_mpid_side           = mpid_side_q;
   assign add_shares              = add_sh_q;
   assign add_mpid_shares         = mpid_sh_q;
   assign add_price               = add_pr_q;
   assign add_mpid_price          = mpid_pr_q;
   assign add_stock_symbol        = add_stk_q;
   assign add_mpid_stock_symbol   = mpid_stk_q;
   assign add_mpid_attribution    = mpid_at_q;
   assign broken_timestamp        = brk_ts_q;
   assign broken_match_id         = brk_mid_q;
endmodule

// File: tb/tb_itch_add_broken_decoder.sv
// Scoreboard bench for itch_add_broken_decoder: directed messages push expected pulses, a monitor checks them.
// Honours ITCH_SIDE_CHECK_EN for the invalid-side case.
module tb_itch_add_broken_decoder;
   logic        clk = 1'b0, rst, valid_in;
   logic [7:0]  byte_in;
   logic        add_internal_valid, add_mpid_internal_valid, broken_internal_valid;
   logic        add_packet_invalid, add_mpid_packet_invalid, broken_packet_invalid;
   logic [3:0]  add_parsed_type, add_mpid_parsed_type, broken_parsed_type;
   logic [63:0] add_order_ref, add_mpid_order_ref, add_stock_symbol, add_mpid_stock_symbol, broken_match_id;
   logic        add_side, add_mpid_side;
   logic [31:0] add_shares, add_mpid_shares, add_price, add_mpid_price, add_mpid_attribution;
   logic [47:0] broken_timestamp;

   itch_add_broken_decoder dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
      .add_internal_valid(add_internal_valid), .add_mpid_internal_valid(add_mpid_internal_valid),
      .broken_internal_valid(broken_internal_valid), .add_packet_invalid(add_packet_invalid),
      .add_mpid_packet_invalid(add_mpid_packet_invalid), .broken_packet_invalid(broken_packet_invalid),
      .add_parsed_type(add_parsed_type), .add_mpid_parsed_type(add_mpid_parsed_type),
      .broken_parsed_type(broken_parsed_type), .add_order_ref(add_order_ref),
      .add_mpid_order_ref(add_mpid_order_ref), .add_side(add_side), .add_mpid_side(add_mpid_side),
      .add_shares(add_shares), .add_mpid_shares(add_mpid_shares), .add_price(add_price),
      .add_mpid_price(add_mpid_price), .add_stock_symbol(add_stock_symbol),
      .add_mpid_stock_symbol(add_mpid_stock_symbol), .add_mpid_attribution(add_mpid_attribution),
      .broken_timestamp(broken_timestamp), .broken_match_id(broken_match_id)
   );

   always #5 clk = ~clk;

   // Pulse order: {add_v, mpid_v, brk_v, add_inv, mpid_inv, brk_inv}
   localparam logic [5:0] P_ADD_V = 6'b100000, P_MPID_V = 6'b010000, P_BRK_V = 6'b001000;
   localparam logic [5:0] P_ADD_I = 6'b000100;

   typedef struct {
      logic [5:0]  pulses;
      int          cyc;
      logic [11:0] ptypes;
      logic [63:0] oref;
      logic        side;
      logic [31:0] shares, price, attr;
      logic [63:0] stock, mid;
      logic [47:0] ts;
   } exp_t;

   int          cyc = 0, total = 0, bad = 0;
   logic [7:0]  msg[$];
   exp_t        sb[$];
   exp_t        cur;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push_be(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) msg.push_back(v[i*8 +: 8]);
   endtask

   task automatic build_add(input logic is_f, input logic [63:0] oref, input logic [7:0] side_b,
                            input logic [31:0] sh, input logic [63:0] stk, input logic [31:0] pr,
                            input logic [31:0] at);
      msg.delete();
      msg.push_back(is_f ? 8'h46 : 8'h41);
      push_be(64'h0001_0002, 4);
      push_be(64'h0000_1111_2222, 6);
      push_be(oref, 8);
      msg.push_back(side_b);
      push_be({32'h0, sh}, 4);
      push_be(stk, 8);
      push_be({32'h0, pr}, 4);
      if (is_f) push_be({32'h0, at}, 4);
      cur = '{default: '0};
      cur.ptypes = is_f ? 12'h020 : 12'h100;
      cur.oref = oref; cur.side = (side_b == 8'h42); cur.shares = sh; cur.stock = stk;
      cur.price = pr; cur.attr = at;
   endtask

   task automatic build_brk(input logic [47:0] ts, input logic [63:0] mid);
      msg.delete();
      msg.push_back(8'h42);
      push_be(64'h0, 4);
      push_be({16'h0, ts}, 6);
      push_be(mid, 8);
      cur = '{default: '0};
      cur.ptypes = 12'h003; cur.ts = ts; cur.mid = mid;
   endtask

   task automatic build_other(input logic [7:0] t, input int n);
      msg.delete();
      msg.push_back(t);
      for (int i = 1; i < n; i++) msg.push_back(8'h30 + 8'(i));
   endtask

   // Truncate to cut bytes when cut>0 (abort follows), register expectation, then drive bytes contiguously.
   task automatic issue(input logic [5:0] pulses, input int cut);
      exp_t e;
      if (cut > 0) while (msg.size() > cut) void'(msg.pop_back());
      if (pulses != 6'b0) begin
         e = cur;
         e.pulses = pulses;
         e.cyc = cyc + msg.size() + ((cut > 0) ? 1 : 0);
         sb.push_back(e);
      end
      for (int i = 0; i < msg.size(); i++) begin
         byte_in = msg[i]; valid_in = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic gap(input int n);
      valid_in = 1'b0; byte_in = 8'h00;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the oldest expectation in order, cycle and field contents.
   always @(negedge clk) begin
      logic [5:0] got;
      exp_t e;
      got = {add_internal_valid, add_mpid_internal_valid, broken_internal_valid,
             add_packet_invalid, add_mpid_packet_invalid, broken_packet_invalid};
      if (got != 6'b0 && !rst) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse got=%b want=none (cycle %0d)", got, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {58'h0, got}, {58'h0, e.pulses});
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            if (e.pulses[5:3] != 3'b0)
               chk("parsed_types", {52'h0, add_parsed_type, add_mpid_parsed_type, broken_parsed_type},
                   {52'h0, e.ptypes});
            if (e.pulses == P_ADD_V) begin
               chk("add_ref", add_order_ref, e.oref);
               chk("add_side", {63'h0, add_side}, {63'h0, e.side});
               chk("add_shares", {32'h0, add_shares}, {32'h0, e.shares});
               chk("add_stock", add_stock_symbol, e.stock);
               chk("add_price", {32'h0, add_price}, {32'h0, e.price});
            end
            if (e.pulses == P_MPID_V) begin
               chk("mpid_ref", add_mpid_order_ref, e.oref);
               chk("mpid_side", {63'h0, add_mpid_side}, {63'h0, e.side});
               chk("mpid_shares", {32'h0, add_mpid_shares}, {32'h0, e.shares});
               chk("mpid_stock", add_mpid_stock_symbol, e.stock);
               chk("mpid_price", {32'h0, add_mpid_price}, {32'h0, e.price});
               chk("mpid_attr", {32'h0, add_mpid_attribution}, {32'h0, e.attr});
            end
            if (e.pulses == P_BRK_V) begin
               chk("brk_ts", {16'h0, broken_timestamp}, {16'h0, e.ts});
               chk("brk_match", broken_match_id, e.mid);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; byte_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pulses", {58'h0, add_internal_valid, add_mpid_internal_valid, broken_internal_valid,
          add_packet_invalid, add_mpid_packet_invalid, broken_packet_invalid}, 64'h0);
      chk("rst_types", {52'h0, add_parsed_type, add_mpid_parsed_type, broken_parsed_type}, 64'h0);
      chk("rst_fields", add_order_ref | add_mpid_stock_symbol | broken_match_id | {16'h0, broken_timestamp}, 64'h0);
      rst = 1'b0;
      gap(2);

      // Basic 'A', 'F', 'B' messages.
      build_add(1'b0, 64'hABCDEF, 8'h42, 32'd100, 64'h4141504C20202020, 32'd1500000, 32'h0);
      issue(P_ADD_V, 0); gap(3);
      build_add(1'b1, 64'h1122334455667788, 8'h53, 32'd200, 64'h4D53465420202020, 32'd12345, 32'h4E534451);
      issue(P_MPID_V, 0); gap(3);
      build_brk(48'h000012345678, 64'h42);
      issue(P_BRK_V, 0); gap(3);

      // Back-to-back 'A', 'D', 'B' with no idle cycles; 'D' must not pulse.
      build_add(1'b0, 64'h0102030405060708, 8'h53, 32'd7, 64'h5445535420202020, 32'd99, 32'h0);
      issue(P_ADD_V, 0);
      build_other(8'h44, 19);
      issue(6'b0, 0);
      build_brk(48'hA1A2A3A4A5A6, 64'hFEDCBA9876543210);
      issue(P_BRK_V, 0); gap(3);

      // Abort after offset 20 of an 'A', then a clean 'A'.
      build_add(1'b0, 64'h5555, 8'h42, 32'd1, 64'h0, 32'd2, 32'h0);
      issue(P_ADD_I, 21); gap(2);
      chk("abort_type_clr", {60'h0, add_parsed_type}, 64'h0);
      build_add(1'b0, 64'hDEADBEEF00000001, 8'h42, 32'd300, 64'h49424D2020202020, 32'd4242, 32'h0);
      issue(P_ADD_V, 0); gap(2);

      // Side byte 'X'.
      build_add(1'b0, 64'h77, 8'h58, 32'd5, 64'h5858585820202020, 32'd6, 32'h0);
`ifdef ITCH_SIDE_CHECK_EN
      issue(P_ADD_I, 0); gap(2);
`else
      issue(P_ADD_V, 0); gap(2);
`endif

      // Unknown type 0x5A is one byte; a zero-gap 'A' right after it must frame correctly.
      build_other(8'h5A, 1);
      issue(6'b0, 0);
      build_add(1'b0, 64'h0A0B0C0D0E0F1011, 8'h42, 32'd8, 64'h5A5A202020202020, 32'd9, 32'h0);
      issue(P_ADD_V, 0); gap(2);

      // Reset mid-message discards it silently.
      build_add(1'b1, 64'h99, 8'h42, 32'd1, 64'h1, 32'd1, 32'h1);
      issue(6'b0, 10);
      rst = 1'b1; valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_type", {60'h0, add_mpid_parsed_type}, 64'h0);
      gap(45);

      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
